main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main.sv | 152 +++++++++++++++
 tb/tb_main.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// main: bottom-up merge sort of signed halfwords held in a 128-byte RAM, with a two-channel byte slave port.
// Define MAIN_INIT_ROM_EN to load a descending array and clear the scratch buffer on every reset cycle.
module main #(
    parameter int MEM_var_28859_28863 = 64,
    parameter int MEM_var_28861_28867 = 32,
    parameter int MEM_var_29020_28863 = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [13:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    output logic        done_port,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy
);
    localparam int N = MEM_var_29020_28863 / 2;
    localparam logic [6:0] ARR = 7'(MEM_var_28859_28863);
    localparam logic [6:0] SCR = 7'(MEM_var_28861_28867);
    localparam logic [6:0] LAST = 7'(N - 1);
    localparam logic [6:0] HALF = 7'(N / 2);
    localparam bit SKIP = N <= 1;

    typedef enum logic [1:0] {IDLE, MERGE, COPY, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ram_q [128];
    logic        ph_q;
    logic [6:0]  o_q, i_q, j_q, w_q;
    logic [15:0] left_q;
    logic [1:0]  rdy_q;
    logic [15:0] rdata_q;

    logic [6:0]  wmask, lo, mid, hi, o_nx, rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic        take, last_o, blk_end, wr_en;
    logic [1:0]  s_ok, s_rd, s_wr;

    // Each merged element takes two cycles: latch the left head, then read the right head and emit the winner.
    always_comb begin
        wmask   = (w_q << 1) - 7'd1;
        lo      = o_q & ~wmask;
        mid     = lo + w_q;
        hi      = lo + (w_q << 1);
        o_nx    = o_q + 7'd1;
        last_o  = o_q == LAST;
        blk_end = (o_nx & wmask) == 7'd0;
        rd_addr = state_q == COPY ? SCR + (o_q << 1) : ARR + ((ph_q ? j_q : i_q) << 1);
        rd_data = {ram_q[rd_addr + 7'd1], ram_q[rd_addr]};
        take    = (i_q < mid) && ((j_q >= hi) || ($signed(left_q) <= $signed(rd_data)));
        wr_en   = !reset && ((state_q == MERGE && ph_q) || state_q == COPY);
        wr_addr = state_q == COPY ? ARR + (o_q << 1) : SCR + (o_q << 1);
        wr_data = (state_q == COPY || !take) ? rd_data : left_q;
    end

    always_comb begin
        s_ok = '0;
        s_rd = '0;
        s_wr = '0;
        for (int c = 0; c < 2; c++) begin
            s_ok[c] = state_q == IDLE && S_data_ram_size[4*c +: 4] == 4'd8;
            s_rd[c] = s_ok[c] && S_oe_ram[c];
            s_wr[c] = s_ok[c] && S_we_ram[c];
        end
    end

    always_comb begin
        state_d = state_q == IDLE  ? (start_port ? MERGE : IDLE)
                : state_q == MERGE ? (SKIP ? DONE : (ph_q && last_o ? COPY : MERGE))
                : state_q == COPY  ? (last_o ? (w_q == HALF ? DONE : MERGE) : COPY)
                : IDLE;
    end

    always_comb begin
        done_port      = state_q == DONE;
        Sout_DataRdy   = rdy_q;
        Sout_Rdata_ram = rdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= 1'b0;
            o_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            w_q     <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                w_q  <= 7'd1;
                o_q  <= '0;
                i_q  <= '0;
                j_q  <= 7'd1;
                ph_q <= 1'b0;
            end else if (state_q == MERGE && !ph_q) begin
                left_q <= rd_data;
                ph_q   <= 1'b1;
            end else if (state_q == MERGE) begin
                ph_q <= 1'b0;
                o_q  <= last_o ? 7'd0 : o_nx;
                i_q  <= blk_end ? o_nx : i_q + 7'(take);
                j_q  <= blk_end ? o_nx + w_q : j_q + 7'(!take);
            end else if (state_q == COPY) begin
                o_q <= last_o ? 7'd0 : o_nx;
                if (last_o) begin
                    w_q <= w_q << 1;
                    i_q <= '0;
                    j_q <= w_q << 1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdy_q   <= '0;
            rdata_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                rdy_q[c]         <= s_ok[c] && (S_oe_ram[c] || S_we_ram[c]);
                rdata_q[8*c +: 8] <= s_rd[c] ? ram_q[S_addr_ram[7*c +: 7]] : 8'h00;
            end
        end
    end

    // Channel 1 is written last so it wins a same-address collision.
    always_ff @(posedge clock) begin
`ifdef MAIN_INIT_ROM_EN
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                ram_q[ARR + 7'(2*k)]     <= 8'(N - 1 - k);
                ram_q[ARR + 7'(2*k + 1)] <= 8'h00;
                ram_q[SCR + 7'(2*k)]     <= 8'h00;
                ram_q[SCR + 7'(2*k + 1)] <= 8'h00;
            end
        end
`endif
        if (!reset) begin
            if (wr_en) begin
                ram_q[wr_addr]        <= wr_data[7:0];
                ram_q[wr_addr + 7'd1] <= wr_data[15:8];
            end
            for (int c = 0; c < 2; c++)
                if (s_wr[c]) ram_q[S_addr_ram[7*c +: 7]] <= S_Wdata_ram[8*c +: 8];
        end
    end
endmodule

// File: tb/tb_main.sv
// tb_main: directed bench for main with a byte-level RAM model, a per-cycle slave-port compare process and literal spot checks.
module tb_main;
    localparam int ARR = 64;
    localparam int N = 16;

    logic        clock = 1'b0, reset = 1'b0, start_port = 1'b0;
    logic [1:0]  S_oe_ram = '0, S_we_ram = '0;
    logic [13:0] S_addr_ram = '0;
    logic [15:0] S_Wdata_ram = '0;
    logic [7:0]  S_data_ram_size = 8'h88;
    logic        done_port;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;

    main dut (
        .clock(clock), .reset(reset), .start_port(start_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, done_cnt = 0;
    bit busy = 1'b0, chk_en = 1'b0;
    logic [7:0]  mem_m [128];
    logic [1:0]  exp_rdy = '0;
    logic [15:0] exp_rd = '0;
    logic [6:0]  ma;
    logic        mok;

    logic signed [15:0] t1  [16] = '{5, -3, 5, 0, -32768, 7, 1, 2, 32767, -1, 100, -100, 3, 3, 0, -2};
    logic signed [15:0] rev [16] = '{7000, 6000, 5000, 4000, 3000, 2000, 1000, 0,
                                     -1000, -2000, -3000, -4000, -5000, -6000, -7000, -8000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave-port model: an access is honoured only while the sorter is idle, not in reset, and sized 8.
    always @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            ma  = S_addr_ram[7*c +: 7];
            mok = !reset && !busy && S_data_ram_size[4*c +: 4] == 4'd8;
            exp_rdy[c]       = mok && (S_oe_ram[c] || S_we_ram[c]);
            exp_rd[8*c +: 8] = (mok && S_oe_ram[c]) ? mem_m[ma] : 8'h00;
        end
        for (int c = 0; c < 2; c++) begin
            ma  = S_addr_ram[7*c +: 7];
            mok = !reset && !busy && S_data_ram_size[4*c +: 4] == 4'd8;
            if (mok && S_we_ram[c]) mem_m[ma] = S_Wdata_ram[8*c +: 8];
        end
`ifdef MAIN_INIT_ROM_EN
        if (reset)
            for (int k = 0; k < N; k++) begin
                mem_m[ARR + 2*k]     = 8'(N - 1 - k);
                mem_m[ARR + 2*k + 1] = 8'h00;
            end
`endif
        if (reset) chk_en = 1'b1;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("slave_rdy", 32'(Sout_DataRdy), 32'(exp_rdy));
            chk("slave_rdata", 32'(Sout_Rdata_ram), 32'(exp_rd));
        end
        if (done_port) done_cnt++;
    end

    task automatic model_sort();
        int v [N];
        int key, j;
        logic [15:0] h;
        for (int k = 0; k < N; k++) v[k] = int'($signed({mem_m[ARR + 2*k + 1], mem_m[ARR + 2*k]}));
        for (int k = 1; k < N; k++) begin
            key = v[k];
            j = k;
            while (j > 0 && v[j-1] > key) begin
                v[j] = v[j-1];
                j--;
            end
            v[j] = key;
        end
        for (int k = 0; k < N; k++) begin
            h = 16'(v[k]);
            mem_m[ARR + 2*k]     = h[7:0];
            mem_m[ARR + 2*k + 1] = h[15:8];
        end
    endtask

    task automatic swr2(input logic [6:0] a0, input logic [7:0] d0, input logic [6:0] a1, input logic [7:0] d1);
        S_we_ram = 2'b11;
        S_addr_ram = {a1, a0};
        S_Wdata_ram = {d1, d0};
        @(negedge clock);
        S_we_ram = 2'b00;
    endtask

    task automatic sread2(input logic [6:0] a0, input logic [6:0] a1);
        S_oe_ram = 2'b11;
        S_addr_ram = {a1, a0};
        @(negedge clock);
        S_oe_ram = 2'b00;
    endtask

    task automatic sread_lit(input string nm, input logic [6:0] a, input logic [7:0] exp);
        S_oe_ram = 2'b01;
        S_addr_ram = {7'd0, a};
        @(negedge clock);
        chk(nm, 32'(Sout_Rdata_ram[7:0]), 32'(exp));
        S_oe_ram = 2'b00;
    endtask

    task automatic write_array(input logic signed [15:0] v [16]);
        for (int k = 0; k < N; k++) swr2(7'(ARR + 2*k), v[k][7:0], 7'(ARR + 2*k + 1), v[k][15:8]);
    endtask

    task automatic read_array();
        for (int k = 0; k < N; k++) sread2(7'(ARR + 2*k), 7'(ARR + 2*k + 1));
    endtask

    task automatic run_sort(input int restart_at, input int probe_at, output int lat);
        int d0;
        busy = 1'b1;
        d0 = done_cnt;
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        lat = 0;
        while (!done_port && lat < 300) begin
            if (lat == restart_at) start_port = 1'b1;
            if (lat == probe_at) begin
                S_oe_ram = 2'b01;
                S_we_ram = 2'b01;
                S_addr_ram = {7'd0, 7'(ARR)};
                S_Wdata_ram = 16'h00EE;
            end
            @(negedge clock);
            start_port = 1'b0;
            S_oe_ram = 2'b00;
            S_we_ram = 2'b00;
            lat++;
        end
        chk("sort_timeout", 32'(lat < 300), 32'd1);
        chk("latency_bound", 32'(lat <= 272), 32'd1);
        @(negedge clock);
        chk("done_one_cycle", 32'(done_port), 32'd0);
        busy = 1'b0;
        repeat (3) @(negedge clock);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        model_sort();
    endtask

    initial begin
        int l1, l2, l3, l4, d0;
        for (int k = 0; k < 128; k++) mem_m[k] = 8'h00;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_done", 32'(done_port), 32'd0);
        chk("reset_rdy", 32'(Sout_DataRdy), 32'd0);
        chk("reset_rdata", 32'(Sout_Rdata_ram), 32'd0);
        reset = 1'b0;
`ifdef MAIN_INIT_ROM_EN
        run_sort(-1, -1, l1);
        read_array();
        sread_lit("rom_el0_lo", 7'(ARR), 8'h00);
        sread_lit("rom_el1_lo", 7'(ARR + 2), 8'h01);
        sread_lit("rom_el15_lo", 7'(ARR + 30), 8'h0F);
`endif
        write_array(t1);
        run_sort(-1, -1, l1);
        read_array();
        sread_lit("min_lo", 7'(ARR), 8'h00);
        sread_lit("min_hi", 7'(ARR + 1), 8'h80);
        sread_lit("el1_lo", 7'(ARR + 2), 8'h9C);
        sread_lit("max_lo", 7'(ARR + 30), 8'hFF);
        sread_lit("max_hi", 7'(ARR + 31), 8'h7F);

        run_sort(-1, -1, l2);
        chk("sorted_input_latency", 32'(l2), 32'(l1));
        read_array();

        write_array(rev);
        run_sort(5, 3, l3);
        chk("restart_latency", 32'(l3), 32'(l1));
        read_array();
        sread_lit("rev_min_lo", 7'(ARR), 8'hC0);
        sread_lit("rev_min_hi", 7'(ARR + 1), 8'hE0);
        sread_lit("rev_max_lo", 7'(ARR + 30), 8'h58);

        busy = 1'b1;
        d0 = done_cnt;
        start_port = 1'b1;
        @(negedge clock);
        start_port = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        busy = 1'b0;
        repeat (30) @(negedge clock);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        write_array(t1);
        run_sort(-1, -1, l4);
        chk("after_abort_latency", 32'(l4), 32'(l1));
        read_array();

        swr2(7'd10, 8'hAA, 7'd10, 8'h55);
        sread_lit("ch1_wins", 7'd10, 8'h55);
        S_data_ram_size = 8'h44;
        swr2(7'd10, 8'h11, 7'd11, 8'h22);
        S_data_ram_size = 8'h88;
        sread_lit("bad_size_ignored", 7'd10, 8'h55);
        sread2(7'd10, 7'(ARR + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
